alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the data word width in bits (two's complement).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port aluCtl, input, 3 bits: [1:0] selects the operation, [2] selects the flag test.
REQ-005 The block SHALL have port inR, input, WIDTH bits, signed: the accumulator (register) operand.
REQ-006 The block SHALL have port inM, input, WIDTH bits, signed: the memory operand.
REQ-007 The block SHALL have port aluOut, output, WIDTH bits, signed: the registered operation result.
REQ-008 The block SHALL have port flag, output, 1 bit: the registered branch-condition flag.
REQ-009 The block SHALL have port ovf, output, 1 bit: registered signed-overflow indicator for the current result.

Function
REQ-010 The block SHALL compute aluOut, flag and ovf from the inputs sampled on a rising clk edge, and present them after that edge (latency 1 cycle, one new result every cycle, no handshake).
REQ-011 aluCtl[1:0]=00 (ADD) SHALL produce inR + inM.
REQ-012 aluCtl[1:0]=01 (SUB) SHALL produce inR - inM.
REQ-013 aluCtl[1:0]=10 (BUMP+) SHALL produce inM + 1.
REQ-014 aluCtl[1:0]=11 (BUMP-) SHALL produce inM - 1.
REQ-015 All arithmetic SHALL wrap modulo 2^WIDTH (no saturation); aluOut holds the low WIDTH bits of the result.
REQ-016 ovf SHALL be 1 when the true signed result is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1], else 0; this applies to all four operations.
REQ-017 aluCtl[2]=0 (zero test) SHALL set flag = 1 when inR equals 0, else 0.
REQ-018 aluCtl[2]=1 (negative test) SHALL set flag = 1 when inR is negative (inR[WIDTH-1]=1), else 0.
REQ-019 flag SHALL depend only on inR and aluCtl[2], never on inM or the operation result.
REQ-020 aluCtl[2] SHALL NOT affect aluOut or ovf.
REQ-021 Inputs SHALL be treated as fully defined every cycle; no input holds or enables exist, so outputs update on every non-reset edge.

Reset
REQ-022 While rst is sampled high on a rising clk edge, aluOut SHALL load 0, flag SHALL load 0 and ovf SHALL load 0, regardless of the other inputs.
REQ-023 Reset asserted mid-stream SHALL discard the in-flight result; the first valid result SHALL appear one cycle after the first edge with rst low.

Structure
REQ-024 A shared package SHALL hold the operation encodings (ALU_ADD=00, ALU_SUB=01, ALU_INC=10, ALU_DEC=11) and the flag-select encodings (FLAG_ZERO=0, FLAG_NEG=1).
REQ-025 The combinational add/subtract datapath with overflow detection SHALL be one sub-module named alu_addsub, with the output registers in alu.

Verification
REQ-026 inR=-3, inM=5, aluCtl[1:0] stepped 00,01,10,11 -> aluOut=2, -8, 6, 4 on successive cycles, with ovf=0 throughout.
REQ-027 inR=0: aluCtl[2]=0 -> flag=1; aluCtl[2]=1 -> flag=0.
REQ-028 inR=-3: aluCtl[2]=0 -> flag=0; aluCtl[2]=1 -> flag=1.
REQ-029 Overflow: ADD with inR=127, inM=1 -> aluOut=-128, ovf=1; BUMP- with inM=-128 -> aluOut=127, ovf=1; SUB with inR=-128, inM=1 -> aluOut=127, ovf=1.
REQ-030 Reset mid-stream: operations running with nonzero results, rst high for one edge -> aluOut=0, flag=0, ovf=0 on the next cycle; the correct result follows one cycle after rst is released.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operation and flag-select fields.
package alu_pkg;

  localparam int unsigned ALU_CTL_W = 3;
  localparam int unsigned ALU_OP_W  = 2;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_INC = 2'b10,
    ALU_DEC = 2'b11
  } alu_op_e;

  typedef enum logic {
    FLAG_ZERO = 1'b0,
    FLAG_NEG  = 1'b1
  } flag_sel_e;

endpackage : alu_pkg

// File: rtl/alu_addsub.sv
// Combinational add/subtract datapath with signed-overflow detection.
module alu_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  alu_op_e          i_op,
  input  logic [WIDTH-1:0] i_r,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH-1:0] o_sum_c,
  output logic             o_ovf_c
);

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_y_eff;
  logic             w_sub;

  // Operand select: ADD/SUB use inR and inM, the bumps use inM and a constant 1.
  always_comb begin
    w_x = i_r;
    w_y = i_m;
    if ((i_op == ALU_INC) || (i_op == ALU_DEC)) begin
      w_x = i_m;
      w_y = WIDTH'(1);
    end
  end

  // Subtraction is x + ~y + 1, so overflow uses the inverted operand's sign.
  assign w_sub   = i_op[0];
  assign w_y_eff = w_sub ? ~w_y : w_y;
  assign o_sum_c = w_x + w_y_eff + WIDTH'(w_sub);
  assign o_ovf_c = (w_x[WIDTH-1] == w_y_eff[WIDTH-1]) &&
                   (o_sum_c[WIDTH-1] != w_x[WIDTH-1]);

endmodule : alu_addsub

// File: rtl/alu.sv
// Single-cycle registered ALU: add/sub/bump with overflow plus a branch flag.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ALU_CTL_W-1:0]    aluCtl,
  input  logic signed [WIDTH-1:0] inR,
  input  logic signed [WIDTH-1:0] inM,
  output logic signed [WIDTH-1:0] aluOut,
  output logic                    flag,
  output logic                    ovf
);

  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic             w_flag;
  logic [WIDTH-1:0] r_out;
  logic             r_flag;
  logic             r_ovf;

  alu_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .i_op    (alu_op_e'(aluCtl[ALU_OP_W-1:0])),
    .i_r     (inR),
    .i_m     (inM),
    .o_sum_c (w_sum),
    .o_ovf_c (w_ovf)
  );

  // Branch flag looks only at inR: zero test or sign test.
  always_comb begin
    w_flag = (inR == '0);
    if (flag_sel_e'(aluCtl[2]) == FLAG_NEG) begin
      w_flag = inR[WIDTH-1];
    end
  end

  // Output registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_flag <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_out  <= w_sum;
      r_flag <= w_flag;
      r_ovf  <= w_ovf;
    end
  end

  assign aluOut = r_out;
  assign flag   = r_flag;
  assign ovf    = r_ovf;

endmodule : alu

// File: tb/tb_alu.sv
// Directed table-driven bench for the registered ALU.
module tb_alu;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NVEC  = 16;

  typedef struct {
    logic             rst;
    logic [2:0]       ctl;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] exp_out;
    logic             exp_flag;
    logic             exp_ovf;
  } vec_t;

  logic                    clk;
  logic                    rst;
  logic [2:0]              aluCtl;
  logic signed [WIDTH-1:0] inR;
  logic signed [WIDTH-1:0] inM;
  logic signed [WIDTH-1:0] aluOut;
  logic                    flag;
  logic                    ovf;

  int n_checks;
  int n_errors;
  vec_t vecs [NVEC];

  alu #(
    .WIDTH (WIDTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .aluCtl (aluCtl),
    .inR    (inR),
    .inM    (inM),
    .aluOut (aluOut),
    .flag   (flag),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_w(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name,
               $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
  task automatic drive(input logic r_rst, input logic [2:0] ctl,
                       input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] m);
    @(negedge clk);
    rst    = r_rst;
    aluCtl = ctl;
    inR    = r;
    inM    = m;
  endtask

  task automatic step_check(input string name, input logic [WIDTH-1:0] e_out,
                            input logic e_flag, input logic e_ovf);
    @(posedge clk);
    #1;
    chk_w({name, " aluOut"}, aluOut, e_out);
    chk_b({name, " flag"}, flag, e_flag);
    chk_b({name, " ovf"}, ovf, e_ovf);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; aluCtl = 3'b000; inR = '0; inM = '0;

    //            rst   ctl     inR    inM    out    flag  ovf
    vecs[0]  = '{1'b1, 3'b100, 8'h05, 8'h07, 8'h00, 1'b0, 1'b0}; // reset wins
    vecs[1]  = '{1'b0, 3'b000, 8'hFD, 8'h05, 8'h02, 1'b0, 1'b0}; // -3+5=2
    vecs[2]  = '{1'b0, 3'b001, 8'hFD, 8'h05, 8'hF8, 1'b0, 1'b0}; // -3-5=-8
    vecs[3]  = '{1'b0, 3'b010, 8'hFD, 8'h05, 8'h06, 1'b0, 1'b0}; // 5+1=6
    vecs[4]  = '{1'b0, 3'b011, 8'hFD, 8'h05, 8'h04, 1'b0, 1'b0}; // 5-1=4
    vecs[5]  = '{1'b0, 3'b100, 8'hFD, 8'h05, 8'h02, 1'b1, 1'b0}; // neg test on -3
    vecs[6]  = '{1'b0, 3'b000, 8'h00, 8'h05, 8'h05, 1'b1, 1'b0}; // zero test on 0
    vecs[7]  = '{1'b0, 3'b100, 8'h00, 8'h05, 8'h05, 1'b0, 1'b0}; // neg test on 0
    vecs[8]  = '{1'b0, 3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1}; // 127+1
    vecs[9]  = '{1'b0, 3'b011, 8'h00, 8'h80, 8'h7F, 1'b1, 1'b1}; // -128-1
    vecs[10] = '{1'b0, 3'b101, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1}; // -128-1 via SUB
    vecs[11] = '{1'b0, 3'b010, 8'h01, 8'h7F, 8'h80, 1'b0, 1'b1}; // 127+1 via INC
    vecs[12] = '{1'b0, 3'b001, 8'h00, 8'h80, 8'h80, 1'b1, 1'b1}; // 0-(-128)=128
    vecs[13] = '{1'b0, 3'b101, 8'h05, 8'hFD, 8'h08, 1'b0, 1'b0}; // 5-(-3)=8
    vecs[14] = '{1'b0, 3'b100, 8'h80, 8'hFF, 8'h7F, 1'b1, 1'b1}; // -128+-1
    vecs[15] = '{1'b0, 3'b000, 8'hC0, 8'hC0, 8'h80, 1'b0, 1'b0}; // -64+-64 fits

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i].rst, vecs[i].ctl, vecs[i].r, vecs[i].m);
      step_check($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_flag, vecs[i].exp_ovf);
    end

    // Reset mid-stream with nonzero results in flight.
    drive(1'b0, 3'b000, 8'h00, 8'h09);
    step_check("pre_rst", 8'h09, 1'b1, 1'b0);
    drive(1'b0, 3'b000, 8'h7F, 8'h7F);
    #1;
    chk_w("latency hold aluOut", aluOut, 8'h09);
    step_check("pre_rst2", 8'hFE, 1'b0, 1'b1);
    drive(1'b1, 3'b000, 8'h00, 8'h14);
    step_check("mid_rst", 8'h00, 1'b0, 1'b0);
    drive(1'b0, 3'b000, 8'h00, 8'h14);
    #1;
    chk_w("rst hold aluOut", aluOut, 8'h00);
    step_check("post_rst", 8'h14, 1'b1, 1'b0);
    drive(1'b0, 3'b101, 8'hF6, 8'h0A);
    step_check("post_rst2", 8'hEC, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_alu
